// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter that shares the single register-file write port among
// several writeback requesters. Acceptance is combinational; the write port
// (W_addr / W_data / wr_enable) and grant_id are registered one cycle later.
// Register 0 writes complete the handshake but never raise wr_enable.
module regfile_write_arbiter #(
    parameter int width   = 32,
    parameter int NUM_REQ = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [5*NUM_REQ-1:0]       req_addr,
    input  logic [width*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [4:0]                 W_addr,
    output logic [width-1:0]           W_data,
    output logic                       wr_enable,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  ptr_next;
    logic [ID_W-1:0]  gnt_idx;
    logic             xfer;
    logic [4:0]       sel_addr;
    logic [width-1:0] sel_data;

    // Search upward from ptr (wrapping) for the first valid requester; stall
    // and reset both suppress acceptance.
    always_comb begin
        int idx;
        idx       = 0;
        xfer      = 1'b0;
        gnt_idx   = '0;
        sel_addr  = '0;
        sel_data  = '0;
        req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!xfer && req_valid[idx]) begin
                xfer     = 1'b1;
                gnt_idx  = ID_W'(idx);
                sel_addr = req_addr[5*idx +: 5];
                sel_data = req_data[width*idx +: width];
            end
        end
        if (stall || !reset) begin
            xfer = 1'b0;
        end
        if (xfer) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // Winner drops to lowest priority: pointer moves just past it.
    always_comb begin
        if (gnt_idx == ID_W'(NUM_REQ - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = gnt_idx + 1'b1;
        end
    end

    // Register the accepted write; idle cycles drop wr_enable and hold the rest.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr       <= '0;
            W_addr    <= '0;
            W_data    <= '0;
            wr_enable <= 1'b0;
            grant_id  <= '0;
        end else begin
            if (xfer) begin
                ptr      <= ptr_next;
                W_addr   <= sel_addr;
                W_data   <= sel_data;
                grant_id <= gnt_idx;
            end
            wr_enable <= xfer && (sel_addr != 5'd0);
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a small register-file model
// fed from the registered write port.
module tb_regfile_write_arbiter;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [2:0]  req_valid;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic [4:0]  W_addr;
    logic [31:0] W_data;
    logic        wr_enable;
    logic [1:0]  grant_id;

    int n_checks = 0;
    int n_errs   = 0;

    logic [31:0] rf [32] = '{default: 32'd0};

    regfile_write_arbiter #(.width(32), .NUM_REQ(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .W_addr    (W_addr),
        .W_data    (W_data),
        .wr_enable (wr_enable),
        .grant_id  (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model: captures the write port on the following edge.
    always @(posedge clk) begin
        if (wr_enable) rf[W_addr] <= W_data;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
        req_addr[5*i +: 5]   = a;
        req_data[32*i +: 32] = d;
    endtask

    initial begin
        reset     = 1'b0;
        stall     = 1'b0;
        req_valid = 3'b111;
        req_addr  = '0;
        req_data  = '0;
        set_req(0, 5'd5, 32'hA);
        set_req(1, 5'd6, 32'hB);
        set_req(2, 5'd7, 32'hC);

        // Reset values with all requesters valid
        tick();
        tick();
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_wen",   32'(wr_enable), 0);
        chk("rst_waddr", 32'(W_addr), 0);
        chk("rst_wdata", W_data, 0);
        chk("rst_gid",   32'(grant_id), 0);

        // Round-robin with all valid: 0,1,2,0,1,2
        reset = 1'b1;
        #1;
        for (int n = 0; n < 6; n++) begin
            int g;
            g = n % 3;
            chk("rr_ready", 32'(req_ready), 32'(1 << g));
            tick();
            chk("rr_gid",   32'(grant_id), g);
            chk("rr_wen",   32'(wr_enable), 1);
            chk("rr_waddr", 32'(W_addr), 5 + g);
            chk("rr_wdata", W_data, 32'hA + g);
        end

        // Zero address from requester 1 (ptr = 0)
        req_valid = 3'b010;
        set_req(1, 5'd0, 32'hDEADBEEF);
        #1;
        chk("z_ready", 32'(req_ready), 2);
        tick();
        req_valid = 3'b000;
        chk("z_wen",   32'(wr_enable), 0);
        chk("z_gid",   32'(grant_id), 1);
        chk("z_wdata", W_data, 32'hDEADBEEF);
        #1;
        chk("z_ready_drop", 32'(req_ready), 0);
        tick();
        tick();
        chk("z_rf0", rf[0], 0);

        // Stall with ptr = 2, requesters 0 and 2 valid
        set_req(0, 5'd9,  32'h90);
        set_req(2, 5'd10, 32'hA0);
        req_valid = 3'b101;
        stall     = 1'b1;
        for (int n = 0; n < 3; n++) begin
            #1;
            chk("st_ready", 32'(req_ready), 0);
            tick();
            chk("st_wen", 32'(wr_enable), 0);
        end
        stall = 1'b0;
        #1;
        chk("st_ready_r2", 32'(req_ready), 4);
        tick();
        chk("st_gid2",   32'(grant_id), 2);
        chk("st_waddr2", 32'(W_addr), 10);
        chk("st_wen2",   32'(wr_enable), 1);
        req_valid = 3'b001;
        #1;
        chk("st_ready_r0", 32'(req_ready), 1);
        tick();
        chk("st_gid0",   32'(grant_id), 0);
        chk("st_waddr0", 32'(W_addr), 9);
        req_valid = 3'b000;

        // Bring ptr from 1 to 0 via a requester 2 transfer
        set_req(2, 5'd11, 32'hB0);
        req_valid = 3'b100;
        #1;
        chk("mv_ready", 32'(req_ready), 4);
        tick();
        req_valid = 3'b000;

        // Same address from requesters 0 and 1, then idle
        set_req(0, 5'd3, 32'h11);
        set_req(1, 5'd3, 32'h22);
        req_valid = 3'b011;
        #1;
        chk("sa_ready0", 32'(req_ready), 1);
        tick();
        chk("sa_wdata0", W_data, 32'h11);
        req_valid = 3'b010;
        #1;
        chk("sa_ready1", 32'(req_ready), 2);
        tick();
        req_valid = 3'b000;
        chk("sa_gid1",   32'(grant_id), 1);
        chk("sa_wdata1", W_data, 32'h22);
        tick();
        chk("idle_wen",   32'(wr_enable), 0);
        chk("idle_waddr", 32'(W_addr), 3);
        chk("idle_wdata", W_data, 32'h22);
        chk("sa_rf3",     rf[3], 32'h22);

        // Reset mid-transfer right after a grant to requester 2 (ptr = 2)
        set_req(0, 5'd13, 32'h130);
        set_req(1, 5'd14, 32'h140);
        set_req(2, 5'd12, 32'h77);
        req_valid = 3'b111;
        #1;
        chk("mr_ready2", 32'(req_ready), 4);
        tick();
        chk("mr_wen_pre", 32'(wr_enable), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("mr_wen",   32'(wr_enable), 0);
        chk("mr_ready", 32'(req_ready), 0);
        chk("mr_gid",   32'(grant_id), 0);
        chk("mr_waddr", 32'(W_addr), 0);
        #1;
        reset = 1'b1;
        #1;
        chk("mr_ready0", 32'(req_ready), 1);
        tick();
        chk("mr_gid0",   32'(grant_id), 0);
        chk("mr_waddr0", 32'(W_addr), 13);
        req_valid = 3'b000;
        tick();
        chk("mr_rf12", rf[12], 0);
        chk("mr_rf13", rf[13], 32'h130);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
